// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified RAM between instruction fetch and the data port.
// Data wins by default; a starvation counter forces an IF grant after STARVE_MAX data wins.
module unified_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;

    logic dreq, starved;

    assign dreq    = mem_rd | mem_wr;
    assign starved = if_req && (starve_q == SMAX);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq && !starved) begin
                    state_d     = BUSY_MEM;
                    owner_d     = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    // rd+wr together is treated as a store
                    ram_we_d    = mem_wr;
                    if (!if_req)
                        starve_d = 4'd0;
                    else if (starve_q != SMAX)
                        starve_d = starve_q + 4'd1;
                end else if (if_req) begin
                    state_d    = BUSY_IF;
                    owner_d    = 1'b0;
                    ram_en_d   = 1'b1;
                    ram_addr_d = if_addr;
                    ram_we_d   = 1'b0;
                    starve_d   = 4'd0;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (ram_ack) begin
                    state_d  = DONE;
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    if (owner_q) begin
                        mem_ready_d = 1'b1;
                        if (!ram_we_q)
                            mem_rdata_d = ram_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end
            end
            // one dead cycle so a request still held during its ready pulse is not re-granted
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            starve_q    <= 4'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a behavioural RAM with programmable ack delay,
// a monitor logging ready pulses, and per-scenario tasks comparing them to expectations.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_ack;

    unified_mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    // RAM model: ack in the ack_delay-th cycle of ram_en (0 = never ack)
    logic [31:0] ram_mem [256];
    int          ack_delay = 1;
    int          en_cnt = 0;
    logic        stray_ack = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 32'h1000_0000 + 32'(i);
            ram_mem[16] <= 32'h2008_0005;
        end else if (ram_en && ram_ack && ram_we) begin
            ram_mem[ram_addr[9:2]] <= ram_wdata;
        end
        en_cnt <= ram_en ? en_cnt + 1 : 0;
    end

    assign ram_rdata = ram_mem[ram_addr[9:2]];
    assign ram_ack   = stray_ack | (ram_en && ack_delay != 0 && en_cnt == ack_delay - 1);

    typedef struct {
        bit          port;   // 0 = IF, 1 = MEM
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  en_cyc = 0, we_cyc = 0, both_hi = 0, if_rdy_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_en) en_cyc <= en_cyc + 1;
        if (ram_en && ram_we) we_cyc <= we_cyc + 1;
        if (if_ready && mem_ready) both_hi <= both_hi + 1;
        if (if_ready) begin
            if_rdy_cyc <= if_rdy_cyc + 1;
            obs_q.push_back('{1'b0, if_rdata, cyc});
        end
        if (mem_ready) obs_q.push_back('{1'b1, mem_rdata, cyc});
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_load = '0;

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en got=%0b want=0", ram_en); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%0b want=0", ram_we); end
        total++; if (ram_addr !== 32'd0) begin bad++; $display("FAIL rst_ram_addr got=%h want=0", ram_addr); end
        total++; if (ram_wdata !== 32'd0) begin bad++; $display("FAIL rst_ram_wdata got=%h want=0", ram_wdata); end
        total++; if (if_rdata !== 32'd0) begin bad++; $display("FAIL rst_if_rdata got=%h want=0", if_rdata); end
        total++; if (mem_rdata !== 32'd0) begin bad++; $display("FAIL rst_mem_rdata got=%h want=0", mem_rdata); end
        total++; if ({if_ready, mem_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", {if_ready, mem_ready}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        int  en0, we0, rdy0, c0;
        bit  done;
        logic [1:0] st;
        ack_delay = 1;
        en0 = en_cyc; we0 = we_cyc; rdy0 = if_rdy_cyc; c0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        exp_q.push_back('{1'b0, 32'h2008_0005, 0});
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (if_ready) begin if_req = 1'b0; done = 1; end
        end
        total++; if (!done) begin bad++; $display("FAIL fetch_timeout got=no_ready want=if_ready"); end
        repeat (3) @(negedge clk);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL fetch_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o.port !== e.port || o.data !== e.data) begin bad++; $display("FAIL fetch_data got=%0b/%h want=%0b/%h", o.port, o.data, e.port, e.data); end
            total++; if (o.cyc - c0 !== 2) begin bad++; $display("FAIL fetch_latency got=%0d want=2", o.cyc - c0); end
        end
        obs_q.delete(); exp_q.delete();
        total++; if (en_cyc - en0 !== 1) begin bad++; $display("FAIL fetch_en_cycles got=%0d want=1", en_cyc - en0); end
        total++; if (we_cyc - we0 !== 0) begin bad++; $display("FAIL fetch_we_cycles got=%0d want=0", we_cyc - we0); end
        total++; if (if_rdy_cyc - rdy0 !== 1) begin bad++; $display("FAIL fetch_ready_width got=%0d want=1", if_rdy_cyc - rdy0); end
        st = dut.state_q;
        total++; if (st !== 2'd0) begin bad++; $display("FAIL fetch_idle got=%0d want=0", st); end
    endtask

    task automatic test_store_load();
        int en0, we0;
        bit done;
        ack_delay = 3;
        en0 = en_cyc; we0 = we_cyc;
        mem_wr = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        exp_q.push_back('{1'b1, last_load, 0});
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (mem_ready) begin mem_wr = 1'b0; done = 1; end
        end
        total++; if (!done) begin bad++; $display("FAIL store_timeout got=no_ready want=mem_ready"); end
        total++; if (we_cyc - we0 !== 3 || en_cyc - en0 !== 3) begin bad++; $display("FAIL store_we_cycles got=%0d/%0d want=3/3", we_cyc - we0, en_cyc - en0); end
        @(negedge clk);
        mem_rd = 1'b1;
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 0});
        last_load = 32'hDEAD_BEEF;
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (mem_ready) begin mem_rd = 1'b0; done = 1; end
        end
        total++; if (!done) begin bad++; $display("FAIL load_timeout got=no_ready want=mem_ready"); end
        repeat (2) @(negedge clk);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL stld_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o.port !== e.port || o.data !== e.data) begin bad++; $display("FAIL stld_data got=%0b/%h want=%0b/%h", o.port, o.data, e.port, e.data); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_simultaneous();
        int b0, n;
        ack_delay = 1;
        b0 = both_hi;
        if_req = 1'b1; if_addr = 32'h44;
        mem_rd = 1'b1; mem_addr = 32'h100;
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 0});
        exp_q.push_back('{1'b0, 32'h1000_0011, 0});
        n = 0;
        for (int k = 0; k < 60 && n < 2; k++) begin
            @(negedge clk);
            if (mem_ready) begin mem_rd = 1'b0; n++; end
            if (if_ready) begin if_req = 1'b0; n++; end
        end
        total++; if (n !== 2) begin bad++; $display("FAIL simul_timeout got=%0d want=2", n); end
        repeat (2) @(negedge clk);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL simul_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() == 2) begin
            total++; if (obs_q[1].cyc - obs_q[0].cyc < 2) begin bad++; $display("FAIL simul_gap got=%0d want>=2", obs_q[1].cyc - obs_q[0].cyc); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o.port !== e.port || o.data !== e.data) begin bad++; $display("FAIL simul_order got=%0b/%h want=%0b/%h", o.port, o.data, e.port, e.data); end
        end
        obs_q.delete(); exp_q.delete();
        total++; if (both_hi !== b0) begin bad++; $display("FAIL simul_both_ready got=%0d want=%0d", both_hi, b0); end
    endtask

    task automatic test_starvation();
        int  mem_n;
        bit  done;
        logic [3:0] sc;
        ack_delay = 1;
        if_req = 1'b1; if_addr = 32'h48;
        mem_rd = 1'b1; mem_addr = 32'h100;
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 0});
        exp_q.push_back('{1'b0, 32'h1000_0012, 0});
        mem_n = 0; done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (mem_ready) mem_n++;
            if (if_ready) begin if_req = 1'b0; mem_rd = 1'b0; done = 1; end
        end
        total++; if (!done) begin bad++; $display("FAIL starve_timeout got=no_if_ready want=if_ready"); end
        total++; if (mem_n !== 4) begin bad++; $display("FAIL starve_mem_grants got=%0d want=4", mem_n); end
        repeat (2) @(negedge clk);
        sc = dut.starve_q;
        total++; if (sc !== 4'd0) begin bad++; $display("FAIL starve_cnt_clear got=%0d want=0", sc); end
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL starve_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o.port !== e.port || o.data !== e.data) begin bad++; $display("FAIL starve_order got=%0b/%h want=%0b/%h", o.port, o.data, e.port, e.data); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [1:0] st;
        ack_delay = 0;
        mem_rd = 1'b1; mem_addr = 32'h100;
        repeat (3) @(negedge clk);
        total++; if (ram_en !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%0b want=1", ram_en); end
        #2 rst = 1'b1;
        #1;
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rstmid_ram_en got=%0b want=0", ram_en); end
        total++; if ({ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata, if_ready, mem_ready} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%h/%h/%h/%h want=all_zero", ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata);
        end
        last_load = '0;
        @(negedge clk);
        mem_rd = 1'b0;
        ack_delay = 1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL rstmid_no_ready got=%0d want=0", obs_q.size()); end
        st = dut.state_q;
        total++; if (st !== 2'd0 || ram_en !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%0d/%0b want=0/0", st, ram_en); end
        obs_q.delete();
    endtask

    task automatic test_illegal();
        int  we0;
        bit  done;
        logic [1:0] st;
        ack_delay = 2;
        we0 = we_cyc;
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h104; mem_wdata = 32'h1234_5678;
        exp_q.push_back('{1'b1, last_load, 0});
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (mem_ready) begin mem_rd = 1'b0; mem_wr = 1'b0; done = 1; end
        end
        total++; if (we_cyc - we0 !== 2) begin bad++; $display("FAIL illegal_we got=%0d want=2", we_cyc - we0); end
        @(negedge clk);
        mem_rd = 1'b1;
        exp_q.push_back('{1'b1, 32'h1234_5678, 0});
        last_load = 32'h1234_5678;
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (mem_ready) begin mem_rd = 1'b0; done = 1; end
        end
        total++; if (!done) begin bad++; $display("FAIL illegal_timeout got=no_ready want=mem_ready"); end
        repeat (2) @(negedge clk);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL illegal_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o.port !== e.port || o.data !== e.data) begin bad++; $display("FAIL illegal_data got=%0b/%h want=%0b/%h", o.port, o.data, e.port, e.data); end
        end
        obs_q.delete(); exp_q.delete();
        // stray ack while idle
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        st = dut.state_q;
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL stray_ready got=%0d want=0", obs_q.size()); end
        total++; if (st !== 2'd0 || ram_en !== 1'b0) begin bad++; $display("FAIL stray_state got=%0d/%0b want=0/0", st, ram_en); end
        total++; if (mem_rdata !== last_load) begin bad++; $display("FAIL stray_mem_rdata got=%h want=%h", mem_rdata, last_load); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
